// File: rtl/pipeline_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
// The skid behaviour is selected at build time with the PIPE_SKID_EN macro.
package pipeline_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_RD_W   = 4;

    // Payload carried through a stage at the default core widths
    typedef struct packed {
        logic [PIPE_RD_W-1:0]   rd;
        logic [PIPE_DATA_W-1:0] data;
        logic                   we;
    } stage_payload_t;

    // Occupancy of the stage: nothing held, main slot only, main and skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Flattened width of an rd/data/we payload
    function automatic int payload_width(input int rd_w, input int data_w);
        return rd_w + data_w + 1;
    endfunction

endpackage

// File: rtl/pipeline_slot.sv
// One payload register with a valid bit. Clear wins over load so a flush
// always empties the slot; the payload bits are only zeroed by reset.
module pipeline_slot
    import pipeline_pkg::*;
#(
    parameter int W = payload_width(PIPE_RD_W, PIPE_DATA_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Hold, load or drop the stored payload
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipeline_skid_register.sv
// Generic valid/ready stage register with flush and write-enable gating.
// Build option PIPE_SKID_EN: adds a skid slot so in_ready is registered and
// has no combinational path from out_ready; without it a single slot is used
// and in_ready = out_ready || !out_valid.
module pipeline_skid_register
    import pipeline_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int RD_W   = PIPE_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we
);

    localparam int PW = payload_width(RD_W, DATA_W);

    // Same layout as stage_payload_t, but at this instance's widths
    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic              we;
    } payload_t;

    payload_t    in_pl;
    payload_t    main_d;
    payload_t    main_q;
    logic [PW-1:0] main_q_raw;
    logic        main_valid;
    logic        main_load;
    logic        main_clear;
    logic        accept;
    logic        leave;
    skid_state_t state;
    skid_state_t state_next;

    // An invalid upstream beat never carries a write request
    assign in_pl  = '{rd: in_rd, data: in_data, we: in_we & in_valid};
    assign accept = in_valid & in_ready;
    assign leave  = main_valid & out_ready;

    assign main_q    = payload_t'(main_q_raw);
    assign out_valid = main_valid;
    assign out_rd    = main_q.rd;
    assign out_data  = main_q.data;
    assign out_we    = main_valid & main_q.we;

    pipeline_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q_raw)
    );

`ifdef PIPE_SKID_EN
    logic          skid_valid;
    logic          skid_load;
    logic          skid_clear;
    logic [PW-1:0] skid_q_raw;
    logic          in_ready_q;

    pipeline_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pl),
        .valid (skid_valid),
        .q     (skid_q_raw)
    );

    assign in_ready = in_ready_q;

    // State register; in_ready is precomputed from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    // Occupancy transitions and slot steering; a leaving main is refilled
    // from the skid slot before any new input is taken
    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_pl;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            state_next = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !leave) begin
                        state_next = TWO;
                        skid_load  = 1'b1;
                    end else if (!accept && leave) begin
                        state_next = EMPTY;
                        main_clear = 1'b1;
                    end else if (accept && leave) begin
                        main_load  = 1'b1;
                    end
                end
                TWO: begin
                    if (leave && skid_valid) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                        main_d     = payload_t'(skid_q_raw);
                        skid_clear = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end
`else
    assign in_ready = out_ready | ~main_valid;

    // State register for the single-slot build
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Single slot: refill on accept, drain when the beat leaves unreplaced
    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_pl;
        if (flush) begin
            state_next = EMPTY;
            main_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept) begin
                        main_load  = 1'b1;
                    end else if (leave) begin
                        state_next = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end
`endif

endmodule
